bcd_counter: RTL and testbench
==============================

// Module: bcd_counter
// PURPOSE
//  Two-digit (00-99) BCD up/down counter that drives the seven-segment display manager.
//  bcd_counter_oport_tens feeds ssd_manager_port_display1; bcd_counter_oport_ones feeds
//  ssd_manager_port_display2. Counting advances one step per prescaled tick. Counting is
//  started and stopped by a raw pushbutton, which is synchronised and edge-detected here.
// PARAMETERS
//  TICK_DIV  100_000_000  clk cycles per count step (1 Hz at 100 MHz); legal range >= 1
//  MAX_TENS  9            tens value at which up-count wraps; the wrap point is MAX_TENS*10+9
// PORTS
//  bcd_counter_clk              in   1  system clock; every flop is clocked on its rising edge
//  bcd_counter_rst              in   1  reset: synchronous, active-high
//  bcd_counter_port_start_stop  in   1  raw pushbutton, asynchronous; each rising edge toggles run/stop
//  bcd_counter_port_clear       in   1  synchronous level clear of the count and the prescaler
//  bcd_counter_port_up_down     in   1  1 = count up, 0 = count down; sampled on the tick cycle
//  bcd_counter_oport_ones       out  4  ones digit, BCD 0-9
//  bcd_counter_oport_tens       out  4  tens digit, BCD 0-MAX_TENS
//  bcd_counter_oport_running    out  1  1 while in state RUNNING
//  bcd_counter_oport_tc         out  1  one-cycle pulse on wrap (up: max->00; down: 00->max)
// BEHAVIOUR
//  Reset (rst=1 at a clock edge):
//   - ones = 0, tens = 0, tc = 0, running = 0, state = STOPPED.
//   - Prescaler = 0; both sync flops = 0; edge-history flop = 0.
//   - Reset overrides every other input.
//  Button path:
//   - Two-flop synchroniser sync1 -> sync2, then history flop prev.
//   - edge = sync2 & ~prev.
//   - The state toggles at the 3rd rising edge after the input is first sampled high.
//   - A held button produces exactly one toggle; a new toggle needs the input to return low.
//  FSM, two states:
//   - STOPPED: on edge -> RUNNING; otherwise stay.
//   - RUNNING: on edge -> STOPPED; otherwise stay.
//   - running = (state == RUNNING), registered.
//  Prescaler, width $clog2(TICK_DIV) (minimum 1):
//   - Increments only in RUNNING.
//   - tick = RUNNING && (presc == TICK_DIV-1); presc wraps to 0 on that cycle.
//   - Holds its value in STOPPED, so a resume finishes the partial period.
//   - TICK_DIV = 1: tick on every RUNNING cycle.
//  Count step on tick, registered; digits and tc update on the same edge:
//   - up, ones < 9: ones + 1.
//   - up, ones == 9, tens < MAX_TENS: ones = 0, tens + 1.
//   - up, at max (MAX_TENS, 9): wrap to 00, tc = 1.
//   - down, ones > 0: ones - 1.
//   - down, ones == 0, tens > 0: ones = 9, tens - 1.
//   - down, at 00: wrap to (MAX_TENS, 9), tc = 1.
//   - tc = 0 on every other cycle.
//  Clear:
//   - Priority: rst > clear > tick.
//   - clear = 1 forces ones = tens = 0, presc = 0, tc = 0.
//   - FSM state is not changed by clear; a button edge in the same cycle still toggles it.
//   - Clear and tick in the same cycle: clear wins, no step, no tc.
//  Digit range:
//   - Digits never leave the BCD range; non-BCD values are unreachable.
//   - No illegal-state recovery is required beyond reset.
//  Direction:
//   - up_down changes between ticks have no effect until the next tick.
// STRUCTURE
//  - Shared header bcd_counter_defs.vh holds:
//     - `define BCD_W 4
//     - FSM state encodings S_STOPPED = 1'b0, S_RUNNING = 1'b1
//     - `define BCD_MAX_ONES 4'd9
//  - One sub-module: tick_gen (parameter TICK_DIV; ports clk, rst, en, clr -> tick).
//    It holds the prescaler. Synchroniser, FSM and BCD logic stay in bcd_counter.
// TESTING (bench runs with TICK_DIV = 4, clk period 10 ns)
//  1. Reset: rst = 1 for 3 cycles -> ones = 0, tens = 0, running = 0, tc = 0.
//     Outputs are static for 50 cycles with the button low.
//  2. Start/hold: start_stop 0->1, held 40 cycles ->
//     - running rises exactly 3 edges after the first high sample, with one toggle only.
//     - Count reaches 10 (tens = 1, ones = 0) after 40 cycles of RUNNING.
//  3. Up-wrap: from 98, up = 1 -> 99, then 00 with tc high for exactly one cycle.
//     Also check the 09 -> 10 carry.
//  4. Down-wrap: from 01, up_down = 0 -> 00, then 99 with a tc pulse.
//     Also check the 10 -> 09 borrow.
//  5. Pause/resume: stop at presc = 2 -> digits frozen for 100 cycles.
//     Restart -> the first step occurs 2 RUNNING cycles (plus sync latency) after the restart edge.
//  6. Clear collision: assert clear on the tick cycle at 57 -> count = 00, no tc, running still 1.
//     The next step occurs TICK_DIV cycles after clear deasserts.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared types, constants and the BCD step function for the two-digit counter.
// Holds the digit width, the largest ones value, the FSM state encodings and
// the digit-pair step used by the counter datapath.
package bcd_counter_pkg;

    // Width of one BCD digit.
    localparam int BCD_W = 4;

    // Largest legal ones digit; also the ones value loaded on a down-wrap.
    localparam logic [BCD_W-1:0] BCD_MAX_ONES = 4'd9;

    // Run/stop state of the counter.
    typedef enum logic {
        S_STOPPED = 1'b0,
        S_RUNNING = 1'b1
    } state_t;

    typedef logic [BCD_W-1:0] bcd_t;

    // Two digits kept together so the whole count moves as one value.
    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd_pair_t;

    // Result of one count step: the new digits and whether the count wrapped.
    typedef struct packed {
        bcd_pair_t val;
        logic      wrap;
    } bcd_step_t;

    // Prescaler width for a given divide ratio; never narrower than one bit
    // so a divide-by-one prescaler still has a legal register.
    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // One up or down step of a two-digit BCD count whose top value is
    // (max_tens, 9). Wrapping in either direction raises the wrap flag.
    function automatic bcd_step_t bcd_step(
        input bcd_pair_t cur,
        input logic      up,
        input bcd_t      max_tens
    );
        bcd_step_t res;
        res.val  = cur;
        res.wrap = 1'b0;
        if (up) begin
            if (cur.ones < BCD_MAX_ONES) begin
                res.val.ones = cur.ones + bcd_t'(1);
            end else if (cur.tens < max_tens) begin
                res.val.ones = '0;
                res.val.tens = cur.tens + bcd_t'(1);
            end else begin
                res.val  = '0;
                res.wrap = 1'b1;
            end
        end else begin
            if (cur.ones > bcd_t'(0)) begin
                res.val.ones = cur.ones - bcd_t'(1);
            end else if (cur.tens > bcd_t'(0)) begin
                res.val.ones = BCD_MAX_ONES;
                res.val.tens = cur.tens - bcd_t'(1);
            end else begin
                res.val.tens = max_tens;
                res.val.ones = BCD_MAX_ONES;
                res.wrap     = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_counter_tick_gen.sv
// Prescaler that turns the system clock into one-cycle count ticks.
// Counts only while enabled and keeps its value when disabled, so a paused
// counter resumes part-way through the period it was stopped in.
module tick_gen
    import bcd_counter_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            PW   = presc_width(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic          w_at_last;

    assign w_at_last = (r_presc == LAST);

    // A clear cycle never produces a tick; the prescaler restarts from zero.
    assign tick = en & w_at_last & ~clr;

    // Prescaler: clear has priority, then count while enabled, wrap on the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (clr) begin
            r_presc <= '0;
        end else if (en) begin
            if (w_at_last) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_counter.sv
// Two-digit BCD up/down counter with a pushbutton run/stop toggle.
// The raw button is synchronised, edge-detected and fed to a two-state FSM;
// while running, the prescaler ticks step the count up or down with wrap.
module bcd_counter
    import bcd_counter_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int MAX_TENS = 9
) (
    input  logic             bcd_counter_clk,
    input  logic             bcd_counter_rst,
    input  logic             bcd_counter_port_start_stop,
    input  logic             bcd_counter_port_clear,
    input  logic             bcd_counter_port_up_down,
    output logic [BCD_W-1:0] bcd_counter_oport_ones,
    output logic [BCD_W-1:0] bcd_counter_oport_tens,
    output logic             bcd_counter_oport_running,
    output logic             bcd_counter_oport_tc
);

    localparam bcd_t MAX_T = bcd_t'(MAX_TENS);

    logic      clk;
    logic      srst;

    logic [1:0] r_sync;
    logic       r_prev;
    logic       w_btn_edge;

    state_t    r_state;
    state_t    w_state_next;
    logic      w_running;

    logic      w_tick;

    bcd_pair_t r_count;
    logic      r_tc;
    bcd_step_t w_step;

    assign clk  = bcd_counter_clk;
    assign srst = bcd_counter_rst;

    // ------------------------------------------------------------------
    // Button path: two synchroniser flops, then a history flop so a held
    // button yields a single edge pulse.
    // ------------------------------------------------------------------

    // Synchroniser chain and edge history for the asynchronous pushbutton.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], bcd_counter_port_start_stop};
            r_prev <= r_sync[1];
        end
    end

    assign w_btn_edge = r_sync[1] & ~r_prev;

    // ------------------------------------------------------------------
    // Run/stop FSM. Clear leaves it alone, so a press during clear still
    // toggles the state.
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= S_STOPPED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: each button edge flips between STOPPED and RUNNING.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_STOPPED: if (w_btn_edge) w_state_next = S_RUNNING;
            S_RUNNING: if (w_btn_edge) w_state_next = S_STOPPED;
            default:   w_state_next = S_STOPPED;
        endcase
    end

    assign w_running = (r_state == S_RUNNING);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (srst),
        .en   (w_running),
        .clr  (bcd_counter_port_clear),
        .tick (w_tick)
    );

    // ------------------------------------------------------------------
    // Count datapath
    // ------------------------------------------------------------------

    assign w_step = bcd_step(r_count, bcd_counter_port_up_down, MAX_T);

    // Count register: clear beats tick; tc is high only on a wrapping tick.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (bcd_counter_port_clear) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (w_tick) begin
            r_count <= w_step.val;
            r_tc    <= w_step.wrap;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign bcd_counter_oport_ones    = r_count.ones;
    assign bcd_counter_oport_tens    = r_count.tens;
    assign bcd_counter_oport_running = w_running;
    assign bcd_counter_oport_tc      = r_tc;

endmodule

// File: tb/tb_bcd_counter.sv
// Directed bench for bcd_counter with TICK_DIV = 4 and a 10 ns clock.
// Inputs change 1 ns after a rising edge and outputs are read at that point.
module tb_bcd_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_stop;
    logic       clear;
    logic       up_down;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       running;
    logic       tc;
    logic [7:0] digits;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign digits = {tens, ones};

    bcd_counter #(
        .TICK_DIV (4),
        .MAX_TENS (9)
    ) dut (
        .bcd_counter_clk             (clk),
        .bcd_counter_rst             (rst),
        .bcd_counter_port_start_stop (start_stop),
        .bcd_counter_port_clear      (clear),
        .bcd_counter_port_up_down    (up_down),
        .bcd_counter_oport_ones      (ones),
        .bcd_counter_oport_tens      (tens),
        .bcd_counter_oport_running   (running),
        .bcd_counter_oport_tc        (tc)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s got=%0h", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Step until the displayed count equals target, bounded by budget cycles.
    task automatic wait_count(input string tag, input logic [7:0] target, input int budget);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (digits !== target && n < budget);
        check_val(tag, 32'(digits), 32'(target));
    endtask

    initial begin
        int bad;
        int tc_seen;

        rst        = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        up_down    = 1'b1;

        // 1. reset and idle
        step(3);
        check_val("rst_ones", 32'(ones), 32'd0);
        check_val("rst_tens", 32'(tens), 32'd0);
        check_val("rst_running", 32'(running), 32'd0);
        check_val("rst_tc", 32'(tc), 32'd0);
        rst = 1'b0;
        bad = 0;
        repeat (50) begin
            step(1);
            if (digits !== 8'h00 || running !== 1'b0 || tc !== 1'b0) bad++;
        end
        check_val("idle_static", 32'(bad), 32'd0);

        // 2. press and hold: toggle on the 3rd edge, 10 steps in 40 running cycles
        start_stop = 1'b1;
        step(1);
        check_val("run_edge1", 32'(running), 32'd0);
        step(1);
        check_val("run_edge2", 32'(running), 32'd0);
        step(1);
        check_val("run_edge3", 32'(running), 32'd1);
        bad     = 0;
        tc_seen = 0;
        for (int e = 4; e <= 43; e++) begin
            step(1);
            if (running !== 1'b1) bad++;
            if (tc === 1'b1) tc_seen++;
            if (e == 39) check_val("count_09", 32'(digits), 32'h09);
            if (e == 42) check_val("carry_pre", 32'(digits), 32'h09);
            if (e == 43) check_val("carry_10", 32'(digits), 32'h10);
        end
        check_val("held_one_toggle", 32'(bad), 32'd0);
        check_val("no_tc_early", 32'(tc_seen), 32'd0);
        start_stop = 1'b0;

        // 3. up-wrap 98 -> 99 -> 00 with a single-cycle tc
        wait_count("reach_98", 8'h98, 400);
        step(3);
        check_val("hold_98", 32'(digits), 32'h98);
        step(1);
        check_val("up_99", 32'(digits), 32'h99);
        check_val("tc_at_99", 32'(tc), 32'd0);
        step(3);
        check_val("hold_99", 32'(digits), 32'h99);
        step(1);
        check_val("up_wrap_00", 32'(digits), 32'h00);
        check_val("tc_up_wrap", 32'(tc), 32'd1);
        step(1);
        check_val("tc_up_once", 32'(tc), 32'd0);

        // 4. down-wrap 01 -> 00 -> 99, then the 10 -> 09 borrow
        step(3);
        check_val("up_01", 32'(digits), 32'h01);
        up_down = 1'b0;
        step(4);
        check_val("dn_00", 32'(digits), 32'h00);
        check_val("tc_dn_00", 32'(tc), 32'd0);
        step(4);
        check_val("dn_wrap_99", 32'(digits), 32'h99);
        check_val("tc_dn_wrap", 32'(tc), 32'd1);
        step(1);
        check_val("tc_dn_once", 32'(tc), 32'd0);
        wait_count("reach_10", 8'h10, 400);
        step(1);
        up_down = 1'b1;
        step(1);
        up_down = 1'b0;
        step(1);
        check_val("hold_10", 32'(digits), 32'h10);
        step(1);
        check_val("borrow_09", 32'(digits), 32'h09);

        // 5. stop with the prescaler at 2, stay frozen, resume finishes the period
        step(3);
        start_stop = 1'b1;
        step(1);
        check_val("dn_08", 32'(digits), 32'h08);
        step(2);
        check_val("stopped", 32'(running), 32'd0);
        start_stop = 1'b0;
        bad = 0;
        repeat (100) begin
            step(1);
            if (digits !== 8'h08 || running !== 1'b0 || tc !== 1'b0) bad++;
        end
        check_val("frozen_100", 32'(bad), 32'd0);
        start_stop = 1'b1;
        step(3);
        check_val("resume_run", 32'(running), 32'd1);
        step(1);
        check_val("resume_wait", 32'(digits), 32'h08);
        step(1);
        check_val("resume_step", 32'(digits), 32'h07);
        start_stop = 1'b0;
        up_down    = 1'b1;

        // 6. clear on the tick cycle at 57
        wait_count("reach_57", 8'h57, 400);
        step(3);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check_val("clr_digits", 32'(digits), 32'h00);
        check_val("clr_tc", 32'(tc), 32'd0);
        check_val("clr_running", 32'(running), 32'd1);
        step(3);
        check_val("clr_hold", 32'(digits), 32'h00);
        step(1);
        check_val("clr_next_01", 32'(digits), 32'h01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
